// File: rtl/clock_mode_ctrl_if.sv
// Key/alarm inputs and display/counter/stopwatch/buzzer controls of the mode sequencer.
// The sequencer connects through the slave modport; its driver connects through master.
interface clock_mode_ctrl_if;
  logic [3:0] key_en;
  logic       alarm_hit;
  logic       alarm_arm;
  logic [1:0] disp_sel;
  logic [3:0] blank;
  logic       time_hr_inc;
  logic       time_min_inc;
  logic       alm_hr_inc;
  logic       alm_min_inc;
  logic       sw_run;
  logic       sw_clr;
  logic       beep_en;
  logic [2:0] state;

  modport master (
    output key_en, alarm_hit, alarm_arm,
    input  disp_sel, blank, time_hr_inc, time_min_inc, alm_hr_inc, alm_min_inc,
    input  sw_run, sw_clr, beep_en, state
  );

  modport slave (
    input  key_en, alarm_hit, alarm_arm,
    output disp_sel, blank, time_hr_inc, time_min_inc, alm_hr_inc, alm_min_inc,
    output sw_run, sw_clr, beep_en, state
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the clock/alarm/stopwatch: decodes key pulses, owns edit/ring
// timeouts and the blink cadence, and drives registered strobes and display controls.
module clock_mode_ctrl #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int BLINK_HZ       = 2,
  parameter int EDIT_TIMEOUT_S = 10,
  parameter int RING_S         = 60
) (
  input  logic             mclk,
  input  logic             rst,
  clock_mode_ctrl_if.slave bus
);
  localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TICK_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SEC_MAX = (EDIT_TIMEOUT_S > RING_S) ? EDIT_TIMEOUT_S : RING_S;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(HALF - 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0]  EDIT_LIMIT = SEC_W'(EDIT_TIMEOUT_S);
  localparam logic [SEC_W-1:0]  RING_LIMIT = SEC_W'(RING_S);

  typedef enum logic [2:0] {
    SHOW  = 3'd0,
    T_HR  = 3'd1,
    T_MIN = 3'd2,
    A_HR  = 3'd3,
    A_MIN = 3'd4,
    SW    = 3'd5,
    RING  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic              sw_run_q, sw_run_d;
  logic              alarm_hit_q, alarm_hit_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              phase_q, phase_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [1:0]        disp_sel_q, disp_sel_d;
  logic [3:0]        blank_q, blank_d;
  logic              time_hr_inc_q, time_hr_inc_d;
  logic              time_min_inc_q, time_min_inc_d;
  logic              alm_hr_inc_q, alm_hr_inc_d;
  logic              alm_min_inc_q, alm_min_inc_d;
  logic              sw_clr_q, sw_clr_d;
  logic              beep_en_q, beep_en_d;

  logic key_any, key_ack, key_mode, key_sel, key_inc;
  logic rise, in_edit, ring_ok;

  always_comb begin
    key_any  = |bus.key_en;
    key_ack  = bus.key_en[3];
    key_mode = bus.key_en[0] & ~bus.key_en[3];
    key_sel  = bus.key_en[1] & ~bus.key_en[3] & ~bus.key_en[0];
    key_inc  = bus.key_en[2] & ~bus.key_en[3] & ~bus.key_en[0] & ~bus.key_en[1];
    alarm_hit_d = bus.alarm_hit;
    rise     = bus.alarm_hit & ~alarm_hit_q;
    in_edit  = (state_q == T_HR) || (state_q == T_MIN) || (state_q == A_HR) || (state_q == A_MIN);
    ring_ok  = (state_q == SHOW) || (state_q == T_HR) || (state_q == T_MIN) || (state_q == SW);

    state_d        = state_q;
    sw_run_d       = sw_run_q;
    time_hr_inc_d  = 1'b0;
    time_min_inc_d = 1'b0;
    alm_hr_inc_d   = 1'b0;
    alm_min_inc_d  = 1'b0;
    sw_clr_d       = 1'b0;

    // An expired edit wins over a key arriving in the same cycle.
    if (state_q == RING) begin
      if (key_ack || !bus.alarm_arm || (sec_q == RING_LIMIT)) state_d = SHOW;
    end else if (rise && bus.alarm_arm && ring_ok) begin
      state_d = RING;
    end else if (in_edit && (sec_q == EDIT_LIMIT)) begin
      state_d = SHOW;
    end else if (key_mode) begin
      case (state_q)
        SHOW:        state_d = T_HR;
        T_HR, T_MIN: state_d = A_HR;
        A_HR, A_MIN: state_d = SW;
        SW:          state_d = SHOW;
        default:     state_d = state_q;
      endcase
    end else if (key_sel) begin
      case (state_q)
        T_HR:    state_d = T_MIN;
        T_MIN:   state_d = T_HR;
        A_HR:    state_d = A_MIN;
        A_MIN:   state_d = A_HR;
        SW:      sw_run_d = ~sw_run_q;
        default: state_d = state_q;
      endcase
    end else if (key_inc) begin
      case (state_q)
        T_HR:    time_hr_inc_d  = 1'b1;
        T_MIN:   time_min_inc_d = 1'b1;
        A_HR:    alm_hr_inc_d   = 1'b1;
        A_MIN:   alm_min_inc_d  = 1'b1;
        SW:      sw_clr_d       = ~sw_run_q;
        default: sw_clr_d       = 1'b0;
      endcase
    end
  end

  // One seconds timer serves both the edit idle timeout and the ring duration.
  always_comb begin
    tick_d = tick_q;
    sec_d  = sec_q;
    if ((state_d != state_q) || !(in_edit || (state_q == RING)) || (in_edit && key_any)) begin
      tick_d = '0;
      sec_d  = '0;
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      sec_d  = sec_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
    end

    half_d  = half_q;
    phase_d = phase_q;
    if (key_any) begin
      half_d  = '0;
      phase_d = 1'b0;
    end else if (half_q == HALF_LAST) begin
      half_d  = '0;
      phase_d = ~phase_q;
    end else begin
      half_d = half_q + 1'b1;
    end
  end

  always_comb begin
    disp_sel_d = 2'd0;
    blank_d    = 4'b0000;
    case (state_d)
      A_HR, A_MIN: disp_sel_d = 2'd1;
      SW:          disp_sel_d = 2'd2;
      default:     disp_sel_d = 2'd0;
    endcase
    if (phase_d && ((state_d == T_HR) || (state_d == A_HR)))  blank_d = 4'b1100;
    if (phase_d && ((state_d == T_MIN) || (state_d == A_MIN))) blank_d = 4'b0011;
    beep_en_d = (state_d == RING) && !phase_d;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q        <= SHOW;
      sw_run_q       <= 1'b0;
      alarm_hit_q    <= 1'b0;
      half_q         <= '0;
      phase_q        <= 1'b0;
      tick_q         <= '0;
      sec_q          <= '0;
      disp_sel_q     <= 2'd0;
      blank_q        <= 4'b0000;
      time_hr_inc_q  <= 1'b0;
      time_min_inc_q <= 1'b0;
      alm_hr_inc_q   <= 1'b0;
      alm_min_inc_q  <= 1'b0;
      sw_clr_q       <= 1'b0;
      beep_en_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sw_run_q       <= sw_run_d;
      alarm_hit_q    <= alarm_hit_d;
      half_q         <= half_d;
      phase_q        <= phase_d;
      tick_q         <= tick_d;
      sec_q          <= sec_d;
      disp_sel_q     <= disp_sel_d;
      blank_q        <= blank_d;
      time_hr_inc_q  <= time_hr_inc_d;
      time_min_inc_q <= time_min_inc_d;
      alm_hr_inc_q   <= alm_hr_inc_d;
      alm_min_inc_q  <= alm_min_inc_d;
      sw_clr_q       <= sw_clr_d;
      beep_en_q      <= beep_en_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.disp_sel     = disp_sel_q;
  assign bus.blank        = blank_q;
  assign bus.time_hr_inc  = time_hr_inc_q;
  assign bus.time_min_inc = time_min_inc_q;
  assign bus.alm_hr_inc   = alm_hr_inc_q;
  assign bus.alm_min_inc  = alm_min_inc_q;
  assign bus.sw_run       = sw_run_q;
  assign bus.sw_clr       = sw_clr_q;
  assign bus.beep_en      = beep_en_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios with literal expectations, then random
// key/alarm/reset traffic checked every cycle against a cycle-count based reference model.
module tb_clock_mode_ctrl;
  localparam int CLK_HZ   = 8;
  localparam int BLINK_HZ = 2;
  localparam int EDIT_S   = 3;
  localparam int RING_S   = 4;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

  localparam logic [3:0] K_MODE = 4'b0001;
  localparam logic [3:0] K_SEL  = 4'b0010;
  localparam logic [3:0] K_INC  = 4'b0100;
  localparam logic [3:0] K_ACK  = 4'b1000;
  localparam logic [3:0] K_NONE = 4'b0000;

  logic mclk = 1'b0;
  logic rst  = 1'b1;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(
    .CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .EDIT_TIMEOUT_S(EDIT_S), .RING_S(RING_S)
  ) dut (
    .mclk(mclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks mode, stopwatch run flag, cycles since the last key and
  // cycles spent idle in the current edit/ring state; outputs follow from those.
  int mode_next[7] = '{1, 3, 3, 5, 5, 0, 6};
  int sel_next[7]  = '{0, 2, 1, 4, 3, 5, 6};
  int m_state = 0;
  int m_since = 0;
  int m_idle  = 0;
  bit m_run = 1'b0, m_hit_prev = 1'b0;
  bit m_thr = 1'b0, m_tmin = 1'b0, m_ahr = 1'b0, m_amin = 1'b0, m_clr = 1'b0;

  function automatic int top_key(input logic [3:0] k);
    if (k[3]) return 3;
    if (k[0]) return 0;
    if (k[1]) return 1;
    if (k[2]) return 2;
    return -1;
  endfunction

  always @(posedge mclk) begin : model
    int key;
    int ns;
    bit rise;
    bit edit;
    m_thr = 0; m_tmin = 0; m_ahr = 0; m_amin = 0; m_clr = 0;
    if (rst) begin
      m_state = 0; m_since = 0; m_idle = 0; m_run = 0; m_hit_prev = 0;
    end else begin
      rise = bus.alarm_hit && !m_hit_prev;
      m_hit_prev = bus.alarm_hit;
      key  = top_key(bus.key_en);
      edit = (m_state >= 1) && (m_state <= 4);
      ns   = m_state;
      if (m_state == 6) begin
        if (key == 3 || !bus.alarm_arm || m_idle == RING_S * CLK_HZ) ns = 0;
      end else if (rise && bus.alarm_arm && m_state != 3 && m_state != 4) begin
        ns = 6;
      end else if (edit && m_idle == EDIT_S * CLK_HZ) begin
        ns = 0;
      end else if (key == 0) begin
        ns = mode_next[m_state];
      end else if (key == 1) begin
        ns = sel_next[m_state];
        if (m_state == 5) m_run = !m_run;
      end else if (key == 2) begin
        m_thr  = (m_state == 1);
        m_tmin = (m_state == 2);
        m_ahr  = (m_state == 3);
        m_amin = (m_state == 4);
        m_clr  = (m_state == 5) && !m_run;
      end
      if (ns != m_state || !(edit || m_state == 6) || (edit && bus.key_en != 0)) m_idle = 0;
      else m_idle++;
      m_since = (bus.key_en != 0) ? 0 : m_since + 1;
      m_state = ns;
    end
  end

  function automatic logic [15:0] model_vec();
    bit         ph;
    logic [1:0] disp;
    logic [3:0] blk;
    bit         beep;
    ph   = ((m_since / HALF) % 2) == 1;
    disp = (m_state == 3 || m_state == 4) ? 2'd1 : (m_state == 5) ? 2'd2 : 2'd0;
    blk  = 4'b0000;
    if (ph && (m_state == 1 || m_state == 3)) blk = 4'b1100;
    if (ph && (m_state == 2 || m_state == 4)) blk = 4'b0011;
    beep = (m_state == 6) && !ph;
    return {3'(m_state), disp, blk, m_thr, m_tmin, m_ahr, m_amin, m_run, m_clr, beep};
  endfunction

  function automatic logic [15:0] act_vec();
    return {bus.state, bus.disp_sel, bus.blank, bus.time_hr_inc, bus.time_min_inc,
            bus.alm_hr_inc, bus.alm_min_inc, bus.sw_run, bus.sw_clr, bus.beep_en};
  endfunction

  always @(negedge mclk) begin
    if (cmp_en) chk("model_outputs", int'(act_vec()), int'(model_vec()));
  end

  // Drive one cycle of inputs, then return at the following negedge with outputs settled.
  task automatic cyc(input logic [3:0] k, input logic hit, input logic arm, input logic r);
    bus.key_en    = k;
    bus.alarm_hit = hit;
    bus.alarm_arm = arm;
    rst           = r;
    @(negedge mclk);
  endtask

  logic [3:0] k_r;
  logic       hit_r, arm_r, rst_r;
  int         busy;

  initial begin
    bus.key_en = 4'b0; bus.alarm_hit = 1'b0; bus.alarm_arm = 1'b0;
    cyc(K_NONE, 0, 0, 1);
    cmp_en = 1'b1;
    cyc(K_NONE, 0, 0, 1);
    chk("reset_outputs", int'(act_vec()), 0);

    // Time edit: MODE, SEL, INC, then blink cadence
    cyc(K_MODE, 0, 0, 0); chk("mode_to_t_hr", int'(bus.state), 1);
    cyc(K_SEL, 0, 0, 0);  chk("sel_to_t_min", int'(bus.state), 2);
    cyc(K_INC, 0, 0, 0);  chk("time_min_inc_hi", int'(bus.time_min_inc), 1);
    chk("blank_after_inc", int'(bus.blank), 0);
    cyc(K_NONE, 0, 0, 0); chk("time_min_inc_lo", int'(bus.time_min_inc), 0);
    chk("blank_hold", int'(bus.blank), 0);
    cyc(K_NONE, 0, 0, 0); chk("blank_min_blink", int'(bus.blank), 4'b0011);

    // Edit timeout
    cyc(K_SEL, 0, 0, 0);  chk("sel_to_t_hr", int'(bus.state), 1);
    repeat (24) cyc(K_NONE, 0, 0, 0);
    chk("timeout_not_yet", int'(bus.state), 1);
    cyc(K_NONE, 0, 0, 0); chk("timeout_show", int'(bus.state), 0);
    cyc(K_MODE, 0, 0, 0);
    repeat (19) cyc(K_NONE, 0, 0, 0);
    cyc(K_INC, 0, 0, 0);  chk("late_inc_hr", int'(bus.time_hr_inc), 1);
    repeat (24) cyc(K_NONE, 0, 0, 0);
    chk("timeout_moved", int'(bus.state), 1);
    cyc(K_NONE, 0, 0, 0); chk("timeout_show2", int'(bus.state), 0);

    // Stopwatch
    repeat (3) cyc(K_MODE, 0, 0, 0);
    chk("sw_state", int'(bus.state), 5);
    chk("sw_disp", int'(bus.disp_sel), 2);
    cyc(K_SEL, 0, 0, 0);  chk("sw_run_on", int'(bus.sw_run), 1);
    cyc(K_INC, 0, 0, 0);  chk("sw_clr_blocked", int'(bus.sw_clr), 0);
    cyc(K_SEL, 0, 0, 0);  chk("sw_run_off", int'(bus.sw_run), 0);
    cyc(K_INC, 0, 0, 0);  chk("sw_clr_pulse", int'(bus.sw_clr), 1);
    cyc(K_MODE, 0, 0, 0); chk("sw_exit", int'(bus.state), 0);
    chk("sw_clr_gone", int'(bus.sw_clr), 0);

    // Ring with ACK, then ring timeout
    cyc(K_NONE, 0, 1, 0);
    cyc(K_NONE, 1, 1, 0); chk("ring_enter", int'(bus.state), 6);
    cyc(K_ACK, 1, 1, 0);  chk("ring_ack", int'(bus.state), 0);
    chk("ring_ack_beep", int'(bus.beep_en), 0);
    cyc(K_NONE, 0, 1, 0);
    cyc(K_NONE, 1, 1, 0); chk("ring_enter2", int'(bus.state), 6);
    repeat (32) cyc(K_NONE, 1, 1, 0);
    chk("ring_hold", int'(bus.state), 6);
    cyc(K_NONE, 1, 1, 0); chk("ring_timeout", int'(bus.state), 0);
    chk("ring_timeout_beep", int'(bus.beep_en), 0);

    // Key priority and alarm ignored while editing the alarm
    cyc(K_MODE, 1, 1, 0); chk("prio_setup", int'(bus.state), 1);
    cyc(4'b0111, 1, 1, 0); chk("prio_mode_wins", int'(bus.state), 3);
    chk("prio_no_inc", int'(bus.time_hr_inc), 0);
    cyc(K_NONE, 0, 1, 0);
    cyc(K_NONE, 1, 1, 0); chk("a_hr_ignores_rise", int'(bus.state), 3);
    chk("a_hr_no_beep", int'(bus.beep_en), 0);

    // Reset during ring with stopwatch running
    cyc(K_MODE, 1, 1, 0);
    cyc(K_SEL, 1, 1, 0);  chk("run_before_ring", int'(bus.sw_run), 1);
    cyc(K_MODE, 1, 1, 0);
    cyc(K_NONE, 0, 1, 0);
    cyc(K_NONE, 1, 1, 0); chk("ring_with_run", int'(bus.state), 6);
    cyc(K_NONE, 1, 1, 1); chk("rst_in_ring", int'(act_vec()), 0);

    // Randomised traffic in segments of varying key density
    hit_r = 1'b1; arm_r = 1'b1;
    for (int seg = 0; seg < 60; seg++) begin
      busy = $urandom_range(0, 2);
      for (int c = 0; c < 50; c++) begin
        k_r = 4'b0;
        if ((busy == 2 && $urandom_range(0, 2) == 0) || (busy == 1 && $urandom_range(0, 11) == 0)) begin
          if ($urandom_range(0, 1) == 0) k_r = 4'(1 << $urandom_range(0, 3));
          else k_r = 4'($urandom_range(1, 15));
        end
        if ($urandom_range(0, 19) == 0) hit_r = ~hit_r;
        if ($urandom_range(0, 39) == 0) arm_r = ~arm_r;
        rst_r = ($urandom_range(0, 399) == 0);
        cyc(k_r, hit_r, arm_r, rst_r);
      end
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
